// File: rtl/pi_map_prog_if.sv
// Processor-interface bus bundle for the programmable address map.
interface pi_map_prog_if;
  logic [31:0] addr;
  logic [7:0]  dato;
  logic        oe;
  logic        we;
  logic        act;
  logic        we_sync;

  modport master (output addr, dato, oe, we, act, we_sync);
  modport slave  (input  addr, dato, oe, we, act, we_sync);
endinterface

// File: rtl/pi_map_prog.sv
// Programmable 64K-granular region decoder with config window, key lock and
// optional write protection (enabled by defining PI_MAP_WP_EN).
module pi_map_prog #(
  parameter int unsigned NREG     = 8,
  parameter logic [8:0]  CFG_BASE = 9'h18F
) (
  input  logic             clk,
  input  logic             rst_n,
  pi_map_prog_if.slave     pi,
  output logic [NREG-1:0]  ce,
  output logic [7:0]       cfg_dout,
  output logic             ce_cfg,
  output logic             wp_fault,
  output logic             locked
);

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_KEY1     = 2'd1,
    ST_LOCKED   = 2'd2
  } lock_st_e;

  localparam logic [7:0] OFF_STATUS = 8'hFE;
  localparam logic [7:0] OFF_LOCK   = 8'hFF;
  localparam logic [7:0] KEY_A      = 8'hA5;
  localparam logic [7:0] KEY_B      = 8'h5A;

  lock_st_e        r_state;
  lock_st_e        w_state_nxt;
  logic            w_locked;

  logic [8:0]      r_base [NREG];
  logic [8:0]      r_mask [NREG];
  logic [NREG-1:0] r_en;
  logic [NREG-1:0] w_wp;

  logic [NREG-1:0] r_ce;
  logic [7:0]      r_cfg_dout;
  logic            r_ce_cfg;

  logic [8:0]      w_a;
  logic [7:0]      w_off;
  logic            w_cfg;
  logic            w_acc;
  logic            w_cfg_wr;
  logic [NREG-1:0] w_win;
  logic            w_viol;
  logic [7:0]      w_rd;
  logic            w_unused;

  assign w_a      = pi.addr[24:16];
  assign w_off    = pi.addr[7:0];
  assign w_cfg    = (w_a == CFG_BASE);
  assign w_acc    = pi.oe | pi.we;
  assign w_cfg_wr = pi.we_sync & pi.act & w_cfg;
  assign w_unused = ^{pi.addr[31:25], pi.addr[15:8]};

  // Lowest-index enabled region whose masked base matches wins.
  always_comb begin : hit_priority
    logic v_found;
    w_win   = '0;
    v_found = 1'b0;
    for (int i = 0; i < NREG; i++) begin
      if (!v_found && r_en[i] && (((w_a ^ r_base[i]) & r_mask[i]) == 9'd0)) begin
        w_win[i] = 1'b1;
        v_found  = 1'b1;
      end
    end
  end

`ifdef PI_MAP_WP_EN
  logic [NREG-1:0] r_wp;
  logic            r_wp_fault;
  logic            w_w1c;

  assign w_wp   = r_wp;
  assign w_viol = pi.we & |(w_win & r_wp);
  assign w_w1c  = w_cfg_wr & (w_off == OFF_STATUS) & pi.dato[0];

  // New violations take precedence over a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin : wp_fault_reg
    if (!rst_n)      r_wp_fault <= 1'b0;
    else if (w_viol) r_wp_fault <= 1'b1;
    else if (w_w1c)  r_wp_fault <= 1'b0;
  end

  assign wp_fault = r_wp_fault;
`else
  assign w_wp     = '0;
  assign w_viol   = 1'b0;
  assign wp_fault = 1'b0;
`endif

  // Region register file; writes land after the strobe edge.
  always_ff @(posedge clk or negedge rst_n) begin : region_regs
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        r_base[i] <= '0;
        r_mask[i] <= '0;
      end
      r_mask[0] <= 9'h180;
      r_en      <= NREG'(1);
`ifdef PI_MAP_WP_EN
      r_wp      <= '0;
`endif
    end else if (w_cfg_wr && !w_locked) begin
      for (int i = 0; i < NREG; i++) begin
        if (w_off[7:2] == 6'(i)) begin
          case (w_off[1:0])
            2'd0: r_base[i][7:0] <= pi.dato;
            2'd1: begin
              r_base[i][8] <= pi.dato[0];
              r_en[i]      <= pi.dato[7];
`ifdef PI_MAP_WP_EN
              r_wp[i]      <= pi.dato[6];
`endif
            end
            2'd2:    r_mask[i][7:0] <= pi.dato;
            default: r_mask[i][8]   <= pi.dato[0];
          endcase
        end
      end
    end
  end

  // Lock FSM: state register.
  always_ff @(posedge clk or negedge rst_n) begin : lock_state
    if (!rst_n) r_state <= ST_UNLOCKED;
    else        r_state <= w_state_nxt;
  end

  // Lock FSM: next state; any non-key config write aborts a half-entered key.
  always_comb begin : lock_next
    w_state_nxt = r_state;
    if (w_cfg_wr) begin
      unique case (r_state)
        ST_UNLOCKED: begin
          if ((w_off == OFF_LOCK) && (pi.dato == KEY_A)) w_state_nxt = ST_KEY1;
        end
        ST_KEY1: begin
          if ((w_off == OFF_LOCK) && (pi.dato == KEY_B))      w_state_nxt = ST_LOCKED;
          else if ((w_off == OFF_LOCK) && (pi.dato == KEY_A)) w_state_nxt = ST_KEY1;
          else                                                w_state_nxt = ST_UNLOCKED;
        end
        ST_LOCKED: w_state_nxt = ST_LOCKED;
        default:   w_state_nxt = ST_UNLOCKED;
      endcase
    end
  end

  // Lock FSM: outputs.
  always_comb begin : lock_out
    w_locked = 1'b0;
    if (r_state == ST_LOCKED) w_locked = 1'b1;
  end

  assign locked = w_locked;

  // Config readback mux from current registered state.
  always_comb begin : readback
    w_rd = '0;
    if (w_off == OFF_STATUS) begin
      w_rd = {w_locked, 6'b0, wp_fault};
    end else if (w_off == OFF_LOCK) begin
      w_rd = {6'b0, r_state};
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (w_off[7:2] == 6'(i)) begin
          case (w_off[1:0])
            2'd0:    w_rd = r_base[i][7:0];
            2'd1:    w_rd = {r_en[i], w_wp[i], 5'b0, r_base[i][8]};
            2'd2:    w_rd = r_mask[i][7:0];
            default: w_rd = {7'b0, r_mask[i][8]};
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin : out_regs
    if (!rst_n) begin
      r_ce       <= '0;
      r_cfg_dout <= '0;
      r_ce_cfg   <= 1'b0;
    end else begin
      r_ce       <= (w_acc && !w_cfg && !w_viol) ? w_win : '0;
      r_cfg_dout <= w_rd;
      r_ce_cfg   <= w_cfg & w_acc;
    end
  end

  assign ce       = r_ce;
  assign cfg_dout = r_cfg_dout;
  assign ce_cfg   = r_ce_cfg;

endmodule

// File: tb/tb_pi_map_prog.sv
// Directed plus randomized check of pi_map_prog against a behavioural address-map model.
module tb_pi_map_prog;

  localparam int unsigned NREG     = 8;
  localparam logic [8:0]  CFG_BASE = 9'h18F;
`ifdef PI_MAP_WP_EN
  localparam bit WP_ON = 1'b1;
`else
  localparam bit WP_ON = 1'b0;
`endif

  logic            clk;
  logic            rst_n;
  logic [NREG-1:0] ce;
  logic [7:0]      cfg_dout;
  logic            ce_cfg;
  logic            wp_fault;
  logic            locked;

  pi_map_prog_if pi_if ();

  pi_map_prog #(.NREG(NREG), .CFG_BASE(CFG_BASE)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .pi       (pi_if),
    .ce       (ce),
    .cfg_dout (cfg_dout),
    .ce_cfg   (ce_cfg),
    .wp_fault (wp_fault),
    .locked   (locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model of the programmable map
  bit [8:0] m_base [NREG];
  bit [8:0] m_mask [NREG];
  bit       m_en   [NREG];
  bit       m_wp   [NREG];
  int       m_state;
  bit       m_wpf;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void m_reset();
    for (int i = 0; i < NREG; i++) begin
      m_base[i] = 0; m_mask[i] = 0; m_en[i] = 0; m_wp[i] = 0;
    end
    m_en[0] = 1; m_mask[0] = 9'h180;
    m_state = 0; m_wpf = 0;
  endfunction

  function automatic int m_winner(bit [8:0] a);
    for (int i = 0; i < NREG; i++)
      if (m_en[i] && (((a ^ m_base[i]) & m_mask[i]) == 0)) return i;
    return -1;
  endfunction

  function automatic bit [7:0] m_read(bit [7:0] off);
    int r;
    if (off == 8'hFE) return {(m_state == 2), 6'b0, m_wpf};
    if (off == 8'hFF) return 8'(m_state);
    if (int'(off) >= 4 * NREG) return 8'h00;
    r = int'(off) / 4;
    case (int'(off) % 4)
      0:       return m_base[r][7:0];
      1:       return {m_en[r], m_wp[r], 5'b0, m_base[r][8]};
      2:       return m_mask[r][7:0];
      default: return {7'b0, m_mask[r][8]};
    endcase
  endfunction

  // One bus cycle: predict, update model, clock, compare every output.
  task automatic step(string tag, logic [31:0] addr, logic [7:0] d,
                      logic oe, logic we, logic act, logic ws);
    bit [8:0]        a;
    bit [7:0]        off;
    bit              cfg, cwr, viol;
    int              win, r;
    logic [NREG-1:0] exp_ce;
    logic [7:0]      exp_dout;
    logic            exp_cecfg;
    pi_if.addr = addr; pi_if.dato = d; pi_if.oe = oe;
    pi_if.we = we; pi_if.act = act; pi_if.we_sync = ws;
    a    = addr[24:16];
    off  = addr[7:0];
    cfg  = (a == CFG_BASE);
    cwr  = cfg && act && ws;
    win  = m_winner(a);
    viol = WP_ON && we && (win >= 0) && m_wp[win];
    exp_ce = '0;
    if ((oe || we) && !cfg && (win >= 0) && !viol) exp_ce[win] = 1'b1;
    exp_dout  = m_read(off);
    exp_cecfg = cfg && (oe || we);
    if (viol) m_wpf = 1;
    else if (cwr && off == 8'hFE && d[0]) m_wpf = 0;
    if (cwr && m_state != 2 && int'(off) < 4 * NREG) begin
      r = int'(off) / 4;
      case (int'(off) % 4)
        0: m_base[r][7:0] = d;
        1: begin m_base[r][8] = d[0]; m_en[r] = d[7]; m_wp[r] = WP_ON ? d[6] : 1'b0; end
        2: m_mask[r][7:0] = d;
        default: m_mask[r][8] = d[0];
      endcase
    end
    if (cwr) begin
      if (m_state == 0) begin
        if (off == 8'hFF && d == 8'hA5) m_state = 1;
      end else if (m_state == 1) begin
        if (off == 8'hFF && d == 8'h5A)      m_state = 2;
        else if (off == 8'hFF && d == 8'hA5) m_state = 1;
        else                                 m_state = 0;
      end
    end
    @(posedge clk); #1;
    chk({tag, ".ce"},       32'(ce),       32'(exp_ce));
    chk({tag, ".cfg_dout"}, 32'(cfg_dout), 32'(exp_dout));
    chk({tag, ".ce_cfg"},   32'(ce_cfg),   32'(exp_cecfg));
    chk({tag, ".wp_fault"}, 32'(wp_fault), 32'(m_wpf));
    chk({tag, ".locked"},   32'(locked),   32'(m_state == 2));
  endtask

  function automatic logic [31:0] cfg_addr(logic [7:0] off);
    return {7'd0, CFG_BASE, 8'd0, off};
  endfunction

  task automatic cfg_wr(string tag, logic [7:0] off, logic [7:0] d);
    step(tag, cfg_addr(off), d, 1'b0, 1'b1, 1'b1, 1'b1);
  endtask

  task automatic cfg_rd(string tag, logic [7:0] off);
    step(tag, cfg_addr(off), 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic bus_rd(string tag, logic [31:0] addr);
    step(tag, addr, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic bus_wr(string tag, logic [31:0] addr);
    step(tag, addr, 8'h3C, 1'b0, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    pi_if.addr = '0; pi_if.dato = '0; pi_if.oe = 1'b0;
    pi_if.we = 1'b0; pi_if.act = 1'b0; pi_if.we_sync = 1'b0;
    #1;
    chk("rst.ce",       32'(ce),       32'h0);
    chk("rst.cfg_dout", 32'(cfg_dout), 32'h0);
    chk("rst.ce_cfg",   32'(ce_cfg),   32'h0);
    chk("rst.wp_fault", 32'(wp_fault), 32'h0);
    chk("rst.locked",   32'(locked),   32'h0);
    m_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rel.ce", 32'(ce), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1;
    pi_if.addr = '0; pi_if.dato = '0; pi_if.oe = 1'b0;
    pi_if.we = 1'b0; pi_if.act = 1'b0; pi_if.we_sync = 1'b0;
    #3;
    do_reset();

    // Reset map: region 0 covers the low 8M only
    bus_rd("r32a", 32'h0012345); chk("r32a.const", 32'(ce), 32'h01);
    bus_rd("r32b", 32'h1000000); chk("r32b.const", 32'(ce), 32'h00);

    // Region 3 at 0x100/0x1F8, then disable region 0
    cfg_wr("r33w", 8'd12, 8'h00); cfg_wr("r33w", 8'd13, 8'h81);
    cfg_wr("r33w", 8'd14, 8'hF8); cfg_wr("r33w", 8'd15, 8'h01);
    bus_rd("r33a", 32'h1050000); chk("r33a.const", 32'(ce), 32'h08);
    cfg_wr("r33d", 8'd1, 8'h00);
    bus_rd("r33b", 32'h0000000); chk("r33b.const", 32'(ce), 32'h00);

    // Overlapping regions 1 and 2: lower index wins
    cfg_wr("r34w", 8'd4, 8'h00);  cfg_wr("r34w", 8'd5, 8'h80);
    cfg_wr("r34w", 8'd6, 8'h00);  cfg_wr("r34w", 8'd7, 8'h00);
    cfg_wr("r34w", 8'd8, 8'h00);  cfg_wr("r34w", 8'd9, 8'h81);
    cfg_wr("r34w", 8'd10, 8'h00); cfg_wr("r34w", 8'd11, 8'h01);
    bus_rd("r34a", 32'h1000000); chk("r34a.const", 32'(ce), 32'h02);
    cfg_rd("r34r", 8'h05);       chk("r34r.const", 32'(cfg_dout), 32'h80);

    // Randomized traffic mixing config writes and data accesses
    for (int k = 0; k < 300; k++) begin
      logic [31:0] ra;
      logic [7:0]  rd;
      int          sel, v;
      ra  = $urandom;
      rd  = 8'($urandom);
      sel = $urandom_range(0, 9);
      if (sel < 4) begin
        v = $urandom_range(0, 40);
        ra[24:16] = CFG_BASE;
        ra[7:0]   = (v < 36) ? 8'(v) : ((v < 39) ? 8'hFE : 8'hFF);
        if (ra[7:0] == 8'hFF) rd = ($urandom_range(0, 1) == 0) ? 8'hA5 : 8'h5A;
        step("rnd_cfg", ra, rd, 1'($urandom), 1'b1,
             ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0));
      end else begin
        if (sel < 7) ra[24:16] = 9'($urandom_range(0, 3) << 7) | 9'($urandom_range(0, 15));
        step("rnd_bus", ra, rd, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      end
    end

    // Write protection on region 2 covering the config window too
    do_reset();
    cfg_wr("wp_set", 8'd10, 8'h80); cfg_wr("wp_set", 8'd11, 8'h01);
    cfg_wr("wp_set", 8'd8, 8'h80);  cfg_wr("wp_set", 8'd9, 8'hC1);
    bus_wr("wp_hit", 32'h1A00000);
`ifdef PI_MAP_WP_EN
    chk("wp_hit.const_ce", 32'(ce), 32'h00); chk("wp_hit.const_f", 32'(wp_fault), 32'h1);
`else
    chk("wp_hit.const_ce", 32'(ce), 32'h04); chk("wp_hit.const_f", 32'(wp_fault), 32'h0);
`endif
    cfg_wr("wp_w1c_viol", 8'hFE, 8'h01);
    chk("wp_w1c_viol.const", 32'(wp_fault), 32'(WP_ON));
    cfg_wr("wp_clr", 8'd9, 8'h81);
    cfg_wr("wp_w1c", 8'hFE, 8'h01);
    chk("wp_w1c.const", 32'(wp_fault), 32'h0);
    bus_wr("wp_off", 32'h1A00000); chk("wp_off.const", 32'(ce), 32'h04);
    cfg_rd("wp_rb", 8'd9);         chk("wp_rb.const", 32'(cfg_dout), 32'h81);

    // Reset in the middle of a key sequence
    cfg_wr("key_a", 8'hFF, 8'hA5);
    cfg_rd("key_rd", 8'hFF); chk("key_rd.const", 32'(cfg_dout), 32'h01);
    do_reset();
    cfg_rd("mrst_ff", 8'hFF); chk("mrst_ff.const", 32'(cfg_dout), 32'h00);
    cfg_rd("mrst_r0", 8'd1);  chk("mrst_r0b1.const", 32'(cfg_dout), 32'h80);
    cfg_rd("mrst_r0", 8'd2);  chk("mrst_r0b2.const", 32'(cfg_dout), 32'h80);
    cfg_rd("mrst_r0", 8'd3);  chk("mrst_r0b3.const", 32'(cfg_dout), 32'h01);
    cfg_rd("mrst_r2", 8'd9);  chk("mrst_r2.const", 32'(cfg_dout), 32'h00);

    // Lock sequence with an interrupting write, then write attempts while locked
    cfg_wr("lk", 8'hFF, 8'hA5);
    cfg_wr("lk_brk", 8'h10, 8'h00);
    cfg_wr("lk", 8'hFF, 8'hA5);
    cfg_wr("lk", 8'hFF, 8'h5A);
    cfg_rd("lk_rd", 8'hFF); chk("lk_rd.const", 32'(cfg_dout), 32'h02);
    chk("lk_rd.const_locked", 32'(locked), 32'h1);
    cfg_wr("lk_wr", 8'd4, 8'h55);
    cfg_rd("lk_rb", 8'd4); chk("lk_rb.const", 32'(cfg_dout), 32'h00);
    cfg_wr("lk_key", 8'hFF, 8'hA5);
    cfg_rd("lk_rd2", 8'hFF); chk("lk_rd2.const", 32'(cfg_dout), 32'h02);
    bus_rd("lk_bus", 32'h0012345); chk("lk_bus.const", 32'(ce), 32'h01);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pi_map_prog.md
PI_MAP_PROG -- requirements
Module: pi_map_prog

Interface
REQ-001 SHALL have parameter NREG, default 8, number of programmable regions (legal 1..16).
REQ-002 SHALL have parameter CFG_BASE, default 9'h18F, addr[24:16] of the 64K config window.
REQ-003 SHALL have port clk  input  1  single system clock; all state on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port pi  input  PiBus  fields addr[31:0], dato[7:0], oe, we, act, we_sync.
REQ-006 SHALL have port ce  output  NREG  registered one-hot region chip-enables.
REQ-007 SHALL have port cfg_dout  output  8  registered config readback byte.
REQ-008 SHALL have port ce_cfg  output  1  registered: current cycle is a config-window access.
REQ-009 SHALL have port wp_fault  output  1  sticky write-protect violation flag.
REQ-010 SHALL have port locked  output  1  config lock state.

Function
REQ-011 SHALL decode regions at 64K granularity on field A = pi.addr[24:16] (9 bits).
REQ-012 SHALL give each region i: base[8:0], mask[8:0], en, wp; config offset 4*i (pi.addr[7:0]).
REQ-013 SHALL map bytes: +0 base[7:0]; +1 bit0 base[8], bit6 wp, bit7 en; +2 mask[7:0]; +3 bit0 mask[8]; unused bits read 0.
REQ-014 SHALL define hit_i = en_i & (((A ^ base_i) & mask_i) == 0).
REQ-015 SHALL resolve multiple hits by priority, lowest index wins; ce stays one-hot or zero.
REQ-016 SHALL treat any access with A == CFG_BASE as config access; config window never asserts any ce bit.
REQ-017 SHALL assert ce[i] one clk after the cycle where (pi.oe | pi.we) and i is the winning hit; latency exactly 1.
REQ-018 SHALL perform config writes only on pi.we_sync & pi.act & config access; one byte per strobe.
REQ-019 SHALL register cfg_dout from pi.addr[7:0] on every clk (1-cycle latency); offsets beyond 4*NREG-1 except 0xFE/0xFF read 8'h00.
REQ-020 SHALL provide status at 0xFE: read {locked, 6'b0, wp_fault}; write bit0=1 clears wp_fault (W1C).
REQ-021 SHALL provide lock FSM at offset 0xFF: UNLOCKED -write 8'hA5-> KEY1 -write 8'h5A-> LOCKED.
REQ-022 SHALL return KEY1 to UNLOCKED on any other config write (any offset/value); A5 in KEY1 stays KEY1.
REQ-023 SHALL ignore all region-register writes while LOCKED; status W1C still honoured; LOCKED exits only by reset.
REQ-024 SHALL read 0xFF as 8'h00 (UNLOCKED), 8'h01 (KEY1), 8'h02 (LOCKED).
REQ-025 SHALL apply a region write from the clk after the strobe; decode in the same cycle as the write uses old values.

Reset
REQ-026 SHALL on rst_n low asynchronously clear ce, cfg_dout, ce_cfg, wp_fault; FSM to UNLOCKED.
REQ-027 SHALL reset region 0 to en=1, wp=0, base=0, mask=9'h180 (addr[24:23]==0, 8M); regions 1..NREG-1 to all zero (disabled).
REQ-028 SHALL abort any in-progress key sequence or access when reset asserts mid-operation; no ce glitch after release.

Configuration
REQ-029 SHALL compile write protection only when PI_MAP_WP_EN is defined.
REQ-030 SHALL, with PI_MAP_WP_EN: on pi.we & winning region wp=1, suppress ce and set wp_fault; set wins over same-cycle W1C.
REQ-031 SHALL, without PI_MAP_WP_EN: wp bits read 0 and ignore writes, no suppression, wp_fault tied 0.

Verification
REQ-032 SHALL test reset: release rst_n, read addr 0x0012345 -> ce == 8'h01 one clk later; addr 0x1000000 -> ce == 0.
REQ-033 SHALL test programming: region 3 base=0x100, mask=0x1F8, en=1; read 0x1050000 -> ce == 8'h08; region 0 disabled read 0x0000000 -> ce == 0.
REQ-034 SHALL test priority: regions 1 and 2 both cover 0x1000000 -> ce == 8'h02; cfg_dout at offset 0x05 == 8'h80.
REQ-035 SHALL test lock: write 0xA5, 0x00@0x10, 0xA5, 0x5A to 0xFF -> 0xFF reads 02; then write base of region 1 -> readback unchanged.
REQ-036 SHALL test WP (macro on): region 2 wp=1, write to its range -> ce == 0, wp_fault == 1; same-cycle W1C plus new violation -> wp_fault stays 1; W1C alone -> 0.
REQ-037 SHALL test mid-sequence reset: write 0xA5 to 0xFF, assert rst_n -> 0xFF reads 00, region 0 restored to reset value.
